soc_onchip_ram_dp: RTL and testbench

Parametrised dual-port on-chip RAM with two Avalon-MM slave ports for the Nios/HPS SoC system. It replaces the fixed 64-bit single-port RAM: data width, depth, byte-lane count and read latency are parameters. Port s1 supports incrementing bursts with a `readdatavalid` pipeline. Port s2 is a single-beat port for a second master, such as a DMA or the HPS bridge, sharing the same array.

---
 rtl/soc_onchip_ram_pkg.sv | 28 ++
 rtl/soc_onchip_ram_array.sv | 49 ++++
 rtl/soc_onchip_ram_dp.sv | 207 ++++++++++++++++++++
 tb/tb_soc_onchip_ram_dp.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_onchip_ram_pkg.sv
// ---------------------------------------------------------------------------
// soc_onchip_ram_pkg
// Shared definitions for the dual-port on-chip RAM:
//   s1_state_e          - s1 burst controller states
//   READ_LATENCY_MIN/MAX - legal read-latency range
//   read_latency_legal() - check a requested read latency
//   be_w()              - byte-lane count for a data width
// ---------------------------------------------------------------------------
package soc_onchip_ram_pkg;

  typedef enum logic [1:0] {
    S1_IDLE   = 2'd0,
    S1_RBURST = 2'd1,
    S1_WBURST = 2'd2
  } s1_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic bit read_latency_legal(input int lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/soc_onchip_ram_array.sv
// ---------------------------------------------------------------------------
// soc_onchip_ram_array
// True-dual-port, byte-enabled RAM with one registered read stage per port.
// Ports (x = a or b):
//   clk        - single clock
//   x_rd_en    - capture mem[x_addr] into x_rdata at this edge
//   x_we       - per-byte-lane write enables
//   x_addr     - word address (caller guarantees < DEPTH)
//   x_wdata    - write data
//   x_rdata    - registered read data (old contents on read-during-write)
// On a same-address, same-lane write from both ports, port a wins.
// ---------------------------------------------------------------------------
module soc_onchip_ram_array
  import soc_onchip_ram_pkg::*;
#(
  parameter int    DATA_W    = 64,
  parameter int    ADDR_W    = 14,
  parameter int    DEPTH     = 12500,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  a_rd_en,
  input  logic [DATA_W/8-1:0]   a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_rd_en,
  input  logic [DATA_W/8-1:0]   b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata
);

  localparam int BE_W = be_w(DATA_W);

  // Power-up contents come from INIT_FILE through the vendor RAM init attribute.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    // Port b lanes are scheduled first so port a overrides on a collision.
    for (int i = 0; i < BE_W; i++) begin
      if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
    if (a_rd_en) a_rdata <= mem[a_addr];
    if (b_rd_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/soc_onchip_ram_dp.sv
// ---------------------------------------------------------------------------
// soc_onchip_ram_dp
// Dual-port on-chip RAM with two Avalon-MM slave ports sharing one array.
//   clk, reset_n (async, active low), clken (global stall when low)
//   s1_*  : burst-capable port (address, byteenable, chipselect, read, write,
//           burstcount, writedata -> waitrequest, readdata, readdatavalid)
//   s2_*  : single-beat port, same signals without burstcount
// Reads return READ_LATENCY cycles after issue; addresses >= DEPTH read as 0
// and silently drop writes; burst addresses wrap from DEPTH-1 to 0.
// ---------------------------------------------------------------------------
module soc_onchip_ram_dp
  import soc_onchip_ram_pkg::*;
#(
  parameter int    DATA_W       = 64,
  parameter int    ADDR_W       = 14,
  parameter int    DEPTH        = 12500,
  parameter int    READ_LATENCY = 2,
  parameter int    BURST_W      = 4,
  parameter string INIT_FILE    = "soc_onchip_ram_dp.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [BURST_W-1:0]  s1_burstcount,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic                s2_waitrequest,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid
);

  localparam int BE_W = be_w(DATA_W);
  // An illegal latency request falls back to the deepest supported pipeline.
  localparam int EFF_LAT = read_latency_legal(READ_LATENCY) ? READ_LATENCY : READ_LATENCY_MAX;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // ---------------- s1 burst controller ----------------
  s1_state_e          state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [BURST_W-1:0] remain_reg, remain_next;
  logic [BURST_W-1:0] first_remain;
  logic               s1_rd_issue, s1_wr_issue;
  logic [ADDR_W-1:0]  s1_beat_addr;

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    remain_next  = remain_reg;
    s1_rd_issue  = 1'b0;
    s1_wr_issue  = 1'b0;
    s1_beat_addr = addr_reg;
    first_remain = (s1_burstcount == '0) ? '0 : s1_burstcount - 1'b1;
    if (clken) begin
      case (state_reg)
        S1_IDLE: begin
          if (s1_chipselect && (s1_read || s1_write)) begin
            s1_beat_addr = s1_address;
            s1_rd_issue  = s1_read;
            s1_wr_issue  = !s1_read;
            addr_next    = next_addr(s1_address);
            remain_next  = first_remain;
            if (first_remain != '0) state_next = s1_read ? S1_RBURST : S1_WBURST;
          end
        end
        S1_RBURST: begin
          s1_rd_issue = 1'b1;
          addr_next   = next_addr(addr_reg);
          remain_next = remain_reg - 1'b1;
          if (remain_reg == BURST_W'(1)) state_next = S1_IDLE;
        end
        S1_WBURST: begin
          // Only write beats advance the burst; a stray read is ignored.
          if (s1_write) begin
            s1_wr_issue = 1'b1;
            addr_next   = next_addr(addr_reg);
            remain_next = remain_reg - 1'b1;
            if (remain_reg == BURST_W'(1)) state_next = S1_IDLE;
          end
        end
        default: state_next = S1_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S1_IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
    end
  end

  assign s1_waitrequest = !clken || (state_reg == S1_RBURST);
  assign s2_waitrequest = !clken;

  // ---------------- array access ----------------
  logic              s2_rd_issue, s2_wr_issue;
  logic              s1_ok, s2_ok;
  logic [ADDR_W-1:0] s1_mem_addr, s2_mem_addr;
  logic [BE_W-1:0]   s1_mem_we, s2_mem_we;
  logic [DATA_W-1:0] mem_q [2];

  assign s2_rd_issue = clken && s2_chipselect && s2_read;
  assign s2_wr_issue = clken && s2_chipselect && s2_write;
  assign s1_ok       = in_range(s1_beat_addr);
  assign s2_ok       = in_range(s2_address);
  // Out-of-range accesses are steered to word 0 and never write.
  assign s1_mem_addr = s1_ok ? s1_beat_addr : '0;
  assign s2_mem_addr = s2_ok ? s2_address : '0;
  assign s1_mem_we   = (s1_wr_issue && s1_ok) ? s1_byteenable : '0;
  assign s2_mem_we   = (s2_wr_issue && s2_ok) ? s2_byteenable : '0;

  soc_onchip_ram_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .a_rd_en (s1_rd_issue),
    .a_we    (s1_mem_we),
    .a_addr  (s1_mem_addr),
    .a_wdata (s1_writedata),
    .a_rdata (mem_q[0]),
    .b_rd_en (s2_rd_issue),
    .b_we    (s2_mem_we),
    .b_addr  (s2_mem_addr),
    .b_wdata (s2_writedata),
    .b_rdata (mem_q[1])
  );

  // ---------------- read return pipeline (index 0 = s1, 1 = s2) ----------------
  logic [1:0]        rd_issue, rd_oor;
  logic [1:0]        v1_reg, oor1_reg;
  logic [1:0]        valid_out;
  logic [DATA_W-1:0] rdata_out [2];

  assign rd_issue = {s2_rd_issue, s1_rd_issue};
  assign rd_oor   = {!s2_ok, !s1_ok};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg   <= '0;
      oor1_reg <= '0;
    end else if (clken) begin
      v1_reg   <= rd_issue;
      oor1_reg <= rd_oor;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] stage1_data;
    // Zero unless a valid in-range beat sits in the memory output register.
    assign stage1_data = (v1_reg[gi] && !oor1_reg[gi]) ? mem_q[gi] : '0;
    if (EFF_LAT == 1) begin : g_lat1
      assign valid_out[gi] = v1_reg[gi];
      assign rdata_out[gi] = stage1_data;
    end else begin : g_lat2
      logic              v2_reg;
      logic [DATA_W-1:0] d2_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2_reg <= 1'b0;
          d2_reg <= '0;
        end else if (clken) begin
          v2_reg <= v1_reg[gi];
          d2_reg <= stage1_data;
        end
      end
      assign valid_out[gi] = v2_reg;
      assign rdata_out[gi] = d2_reg;
    end
  end

  // A stalled pipeline holds its beats but must not present them.
  assign s1_readdatavalid = clken && valid_out[0];
  assign s2_readdatavalid = clken && valid_out[1];
  assign s1_readdata      = rdata_out[0];
  assign s2_readdata      = rdata_out[1];

endmodule

// File: tb/tb_soc_onchip_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_soc_onchip_ram_dp
// Directed and random traffic on both ports of soc_onchip_ram_dp, compared
// every cycle against a behavioural memory model with timed return queues.
// ---------------------------------------------------------------------------
module tb_soc_onchip_ram_dp;

  localparam int DEPTH   = 12500;
  localparam int LAT     = 2;
  localparam int BURST_W = 4;

  logic        clk = 1'b0;
  logic        reset_n, clken;
  logic [13:0] s1_address, s2_address;
  logic [7:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_burstcount;
  logic [63:0] s1_writedata, s2_writedata;
  logic        s1_waitrequest, s2_waitrequest;
  logic [63:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;

  always #5 clk = ~clk;

  soc_onchip_ram_dp dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata),
    .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct packed { int due; logic [63:0] data; } rd_item_t;
  logic [63:0] ref_mem [DEPTH];
  rd_item_t    q1[$], q2[$];
  int          ecnt = 0;          // clock edges seen with clken high
  int          rb_left = 0, wb_left = 0;
  logic [13:0] rb_addr = '0, wb_addr = '0;
  logic [63:0] cap1[$];
  logic [63:0] wbuf [16];

  function automatic logic [13:0] wrap_inc(input logic [13:0] a);
    if (a == 14'(DEPTH - 1)) return '0;
    return a + 14'd1;
  endfunction

  function automatic logic [63:0] model_read(input logic [13:0] a);
    if (int'(a) >= DEPTH) return '0;
    return ref_mem[a];
  endfunction

  task automatic model_write(input logic [13:0] a, input logic [7:0] be, input logic [63:0] d);
    if (int'(a) < DEPTH)
      for (int i = 0; i < 8; i++)
        if (be[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare outputs mid-cycle against the model.
  task automatic check_cycle();
    bit ev1, ev2;
    if (!reset_n) begin
      q1.delete(); q2.delete(); rb_left = 0; wb_left = 0;
    end
    ev1 = clken && reset_n && (q1.size() > 0) && (q1[0].due == ecnt);
    ev2 = clken && reset_n && (q2.size() > 0) && (q2[0].due == ecnt);
    check("s1_waitrequest", s1_waitrequest, !clken || (rb_left > 0));
    check("s2_waitrequest", s2_waitrequest, !clken);
    check("s1_readdatavalid", s1_readdatavalid, ev1);
    check("s2_readdatavalid", s2_readdatavalid, ev2);
    if (ev1) begin
      check("s1_readdata", s1_readdata, q1[0].data);
      q1.pop_front();
    end
    if (ev2) begin
      check("s2_readdata", s2_readdata, q2[0].data);
      q2.pop_front();
    end
    if (s1_readdatavalid) begin
      cap1.push_back(s1_readdata);
      $display("[%0t] s1 read beat data=%h", $time, s1_readdata);
    end
    if (s2_readdatavalid) $display("[%0t] s2 read beat data=%h", $time, s2_readdata);
  endtask

  // Apply the effect of the clock edge that just occurred.
  task automatic model_edge();
    bit r1 = 1'b0, w1 = 1'b0;
    logic [13:0] a1 = '0;
    if (!reset_n || !clken) return;
    if (rb_left > 0) begin
      r1 = 1'b1; a1 = rb_addr; rb_addr = wrap_inc(rb_addr); rb_left--;
    end else if (wb_left > 0) begin
      if (s1_write) begin
        w1 = 1'b1; a1 = wb_addr; wb_addr = wrap_inc(wb_addr); wb_left--;
      end
    end else if (s1_chipselect && s1_read) begin
      r1 = 1'b1; a1 = s1_address;
      rb_left = (s1_burstcount == 0) ? 0 : int'(s1_burstcount) - 1;
      rb_addr = wrap_inc(s1_address);
    end else if (s1_chipselect && s1_write) begin
      w1 = 1'b1; a1 = s1_address;
      wb_left = (s1_burstcount == 0) ? 0 : int'(s1_burstcount) - 1;
      wb_addr = wrap_inc(s1_address);
    end
    // Reads see the contents from before this edge's writes.
    if (r1) q1.push_back('{due: ecnt + LAT, data: model_read(a1)});
    if (s2_chipselect && s2_read) q2.push_back('{due: ecnt + LAT, data: model_read(s2_address)});
    if (s2_chipselect && s2_write) model_write(s2_address, s2_byteenable, s2_writedata);
    if (w1) model_write(a1, s1_byteenable, s1_writedata);
    ecnt++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    repeat (n) step();
  endtask

  task automatic s1_wr_burst(input logic [13:0] a, input int n, input logic [7:0] be);
    $display("[%0t] s1 write burst addr=%0d len=%0d", $time, a, n);
    for (int i = 0; i < n; i++) begin
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
      s1_address = a; s1_burstcount = 4'(n); s1_byteenable = be;
      s1_writedata = wbuf[i];
      step();
    end
    s1_chipselect = 1'b0; s1_write = 1'b0;
  endtask

  task automatic s1_rd_burst(input logic [13:0] a, input int n);
    $display("[%0t] s1 read burst addr=%0d len=%0d", $time, a, n);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0;
    s1_address = a; s1_burstcount = 4'(n);
    step();
    s1_chipselect = 1'b0; s1_read = 1'b0;
  endtask

  function automatic logic [13:0] pick_addr();
    case ($urandom_range(2))
      0:       return 14'($urandom_range(20));
      1:       return 14'($urandom_range(12499, 12485));
      default: return 14'($urandom_range(12520, 12500));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_v;
    clken = 1'b1; reset_n = 1'b1; idle_inputs();
    s1_address = '0; s1_byteenable = '1; s1_burstcount = 4'd1; s1_writedata = '0;
    s2_address = '0; s2_byteenable = '1; s2_writedata = '0;
    #1 reset_n = 1'b0;
    repeat (3) step();
    check("rst_s1_readdata", s1_readdata, 64'd0);
    check("rst_s2_readdata", s2_readdata, 64'd0);
    check("rst_s1_valid", {63'd0, s1_readdatavalid}, 64'd0);
    reset_n = 1'b1;
    step();

    // Preload the regions used by random traffic through s2.
    for (int i = 0; i < 52; i++) begin
      s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0; s2_byteenable = '1;
      s2_address = (i < 32) ? 14'(i) : 14'(12480 + i - 32);
      s2_writedata = {$urandom, $urandom};
      step();
    end
    idle(1);

    // Single write then read at address 5.
    cap1.delete();
    wbuf[0] = 64'h1122334455667788;
    s1_wr_burst(14'd5, 1, 8'hFF);
    s1_rd_burst(14'd5, 1);
    idle(4);
    check("single_count", cap1.size(), 1);
    if (cap1.size() > 0) check("single_data", cap1[0], 64'h1122334455667788);

    // Four-beat burst across the top of the array.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hB0B0_0000_0000_0000 + 64'(i);
    s1_wr_burst(14'd12497, 4, 8'hFF);
    cap1.delete();
    s1_rd_burst(14'd12497, 4);
    idle(6);
    check("wrap_count", cap1.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < cap1.size()) check("wrap_data", cap1[i], 64'hB0B0_0000_0000_0000 + 64'(i));

    // Same-cycle collision at address 7.
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0; s1_address = 14'd7;
    s1_burstcount = 4'd1; s1_byteenable = 8'h0F; s1_writedata = 64'hAAAA_AAAA_AAAA_AAAA;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0; s2_address = 14'd7;
    s2_byteenable = 8'hFF; s2_writedata = 64'h5555_5555_5555_5555;
    $display("[%0t] collision write addr=7", $time);
    step();
    idle_inputs();
    cap1.delete();
    s1_rd_burst(14'd7, 1);
    idle(4);
    check("collision_count", cap1.size(), 1);
    if (cap1.size() > 0) check("collision_data", cap1[0], 64'h5555_5555_AAAA_AAAA);

    // Out-of-range read and dropped write.
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0; s2_address = 14'd100;
    s2_byteenable = 8'hFF; s2_writedata = 64'h0123_4567_89AB_CDEF;
    step();
    idle_inputs();
    cap1.delete();
    s1_rd_burst(14'd12600, 1);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    s1_wr_burst(14'd12600, 1, 8'hFF);
    s1_rd_burst(14'd100, 1);
    idle(4);
    check("oor_count", cap1.size(), 2);
    if (cap1.size() > 1) begin
      check("oor_read_zero", cap1[0], 64'd0);
      check("oor_addr100", cap1[1], 64'h0123_4567_89AB_CDEF);
    end

    // Eight-beat read burst with clken low for three cycles.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    s1_wr_burst(14'd200, 8, 8'hFF);
    cap1.delete();
    s1_rd_burst(14'd200, 8);
    idle(2);
    clken = 1'b0;
    idle(3);
    clken = 1'b1;
    idle(12);
    check("clken_count", cap1.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < cap1.size()) check("clken_data", cap1[i], 64'hC0DE_0000_0000_0000 + 64'(i));

    // Reset during the second beat of an eight-beat read burst.
    s1_rd_burst(14'd200, 8);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, s1_readdatavalid}, 64'd0);
    check("rst_mid_wait", {63'd0, s1_waitrequest}, 64'd0);
    step();
    reset_n = 1'b1;
    idle(2);
    cap1.delete();
    s1_rd_burst(14'd205, 1);
    idle(4);
    check("rst_keep_count", cap1.size(), 1);
    if (cap1.size() > 0) check("rst_keep_data", cap1[0], 64'hC0DE_0000_0000_0005);

    // Random traffic on both ports.
    for (int c = 0; c < 400; c++) begin
      clken = ($urandom_range(9) != 0);
      s2_chipselect = 1'($urandom_range(1)); s2_read = 1'($urandom_range(1));
      s2_write = 1'($urandom_range(1)); s2_address = pick_addr();
      s2_byteenable = 8'($urandom); s2_writedata = {$urandom, $urandom};
      s1_chipselect = 1'($urandom_range(1)); s1_read = 1'($urandom_range(1));
      s1_write = ($urandom_range(3) != 0); s1_address = pick_addr();
      s1_burstcount = 4'($urandom_range(8)); s1_byteenable = 8'($urandom);
      s1_writedata = {$urandom, $urandom};
      step();
    end
    clken = 1'b1;
    idle(20);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);
    exp_v = 64'(rb_left);
    check("drain_rburst", exp_v, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
